// File: rtl/regbank_context_engine.sv
// Context save/restore engine for the register bank: SAVE streams registers 0..NUM_REGS-1 out,
// RESTORE writes NUM_REGS incoming stream words into registers 0..NUM_REGS-1.
module regbank_context_engine #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              save_start,
  input  logic              restore_start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rb_read_addr,
  input  logic [DATA_W-1:0] rb_read_data,
  output logic              rb_write,
  output logic [ADDR_W-1:0] rb_write_addr,
  output logic [DATA_W-1:0] rb_write_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] NumRegs = CntW'(NUM_REGS);
  localparam logic [CntW-1:0] LastIdx = CntW'(NUM_REGS - 1);

  typedef enum logic [1:0] {StIdle, StSave, StRestore, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     rd_idx_q, rd_idx_d;
  logic [CntW-1:0]     wr_idx_q, wr_idx_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                rb_write_q, rb_write_d;
  logic [ADDR_W-1:0]   rb_write_addr_q, rb_write_addr_d;
  logic [DATA_W-1:0]   rb_write_data_q, rb_write_data_d;

  logic save_load, out_xfer, in_acc;

  assign in_ready  = (state_q == StRestore) && (wr_idx_q < NumRegs);
  assign in_acc    = in_valid && in_ready;
  assign out_xfer  = out_valid_q && out_ready;
  // Output stage refills whenever it is empty or draining this cycle.
  assign save_load = (state_q == StSave) && (rd_idx_q < NumRegs) && (!out_valid_q || out_ready);

  always_comb begin
    state_d         = state_q;
    rd_idx_d        = rd_idx_q;
    wr_idx_d        = wr_idx_q;
    out_valid_d     = out_valid_q;
    out_last_d      = out_last_q;
    out_data_d      = out_data_q;
    rb_write_d      = 1'b0;
    rb_write_addr_d = rb_write_addr_q;
    rb_write_data_d = rb_write_data_q;
    case (state_q)
      StIdle: begin
        if (save_start) begin
          state_d = StSave;
        end else if (restore_start) begin
          state_d = StRestore;
        end
      end
      StSave: begin
        if (out_xfer) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = StDone;
          end
        end
        if (save_load) begin
          out_valid_d = 1'b1;
          out_data_d  = rb_read_data;
          out_last_d  = (rd_idx_q == LastIdx);
          rd_idx_d    = rd_idx_q + 1'b1;
        end
      end
      StRestore: begin
        if (in_acc) begin
          rb_write_d      = 1'b1;
          rb_write_addr_d = wr_idx_q[ADDR_W-1:0];
          rb_write_data_d = in_data;
          wr_idx_d        = wr_idx_q + 1'b1;
        end
        // Counter already full: this cycle carries the final write.
        if (wr_idx_q == NumRegs) begin
          state_d = StDone;
        end
      end
      StDone: begin
        rd_idx_d   = '0;
        wr_idx_d   = '0;
        out_last_d = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      rd_idx_q        <= '0;
      wr_idx_q        <= '0;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
      out_data_q      <= '0;
      rb_write_q      <= 1'b0;
      rb_write_addr_q <= '0;
      rb_write_data_q <= '0;
    end else begin
      state_q         <= state_d;
      rd_idx_q        <= rd_idx_d;
      wr_idx_q        <= wr_idx_d;
      out_valid_q     <= out_valid_d;
      out_last_q      <= out_last_d;
      out_data_q      <= out_data_d;
      rb_write_q      <= rb_write_d;
      rb_write_addr_q <= rb_write_addr_d;
      rb_write_data_q <= rb_write_data_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign rb_read_addr  = rd_idx_q[ADDR_W-1:0];
  assign rb_write      = rb_write_q;
  assign rb_write_addr = rb_write_addr_q;
  assign rb_write_data = rb_write_data_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;
  assign out_data      = out_data_q;

endmodule

// File: tb/tb_regbank_context_engine.sv
// Scoreboard bench for regbank_context_engine: a behavioural bank model predicts stream beats and
// bank writes; a negedge monitor pops and compares whatever the DUT presents.
module tb_regbank_context_engine;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          save_start = 1'b0, restore_start = 1'b0;
  logic          busy, done;
  logic [AW-1:0] rb_read_addr;
  logic [DW-1:0] rb_read_data;
  logic          rb_write;
  logic [AW-1:0] rb_write_addr;
  logic [DW-1:0] rb_write_data;
  logic          out_valid, out_last;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;

  regbank_context_engine #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .save_start(save_start), .restore_start(restore_start),
    .busy(busy), .done(done), .rb_read_addr(rb_read_addr), .rb_read_data(rb_read_data),
    .rb_write(rb_write), .rb_write_addr(rb_write_addr), .rb_write_data(rb_write_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  always #5 clk = ~clk;

  // Register bank environment; preloaded while preload is set.
  logic [DW-1:0] bank [NR];
  logic          preload = 1'b1;
  assign rb_read_data = bank[rb_read_addr];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NR; i++) bank[i] <= 64'h1000 + 64'(i);
    end else if (rb_write) begin
      bank[rb_write_addr] <= rb_write_data;
    end
  end

  typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;
  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;

  beat_t         exp_beats[$];
  wr_t           exp_wr[$];
  logic [DW-1:0] model_bank [NR];
  int            errors = 0, checks = 0;
  int            cycle = 0, start_cyc = 0, first_beat_cyc = 0, last_beat_cyc = 0;
  int            beats = 0, done_cnt = 0;
  bit            save_mode = 0, in_ready_seen = 0, stalled = 0;
  logic [DW-1:0] stall_data;
  beat_t         got_b;
  wr_t           got_w;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (save_mode && in_ready) in_ready_seen = 1;
      if (stalled) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", out_data, stall_data);
      end
      stalled    = out_valid && !out_ready;
      stall_data = out_data;
      if (out_valid && out_ready) begin
        if (beats == 0) first_beat_cyc = cycle;
        last_beat_cyc = cycle;
        beats++;
        if (exp_beats.size() == 0) begin
          check("unexpected_beat", out_data, 64'hX);
        end else begin
          got_b = exp_beats.pop_front();
          check("beat_data", out_data, got_b.data);
          check("beat_last", 64'(out_last), 64'(got_b.last));
        end
      end
      if (rb_write) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 64'(rb_write_addr), 64'hX);
        end else begin
          got_w = exp_wr.pop_front();
          check("write_addr", 64'(rb_write_addr), 64'(got_w.addr));
          check("write_data", rb_write_data, got_w.data);
        end
      end
    end
  end

  function automatic logic ready_pat(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 3) == 0;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"}, out_data, 64'd0);
    check({tag, "_out_last"}, 64'(out_last), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_rb_write"}, 64'(rb_write), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
  endtask

  task automatic push_save();
    beat_t b;
    for (int i = 0; i < NR; i++) begin
      b.data = model_bank[i];
      b.last = (i == NR - 1);
      exp_beats.push_back(b);
    end
  endtask

  task automatic run_save(input int mode, input bit both);
    int n = 0;
    done_cnt = 0; beats = 0; in_ready_seen = 0; save_mode = 1;
    push_save();
    save_start = 1; restore_start = both; out_ready = ready_pat(mode, 0); start_cyc = cycle;
    @(posedge clk); #1;
    save_start = 0; restore_start = 0;
    while (!done && n < 2000) begin
      out_ready = ready_pat(mode, n + 1);
      restore_start = (n == 4);  // ignored while busy
      @(posedge clk); #1;
      n++;
    end
    restore_start = 0; out_ready = 0;
    check("save_timeout", 64'(n >= 2000), 64'd0);
    @(posedge clk); #1;
    save_mode = 0;
    check("save_busy_after", 64'(busy), 64'd0);
    check("save_done_pulses", 64'(done_cnt), 64'd1);
    check("save_beats_left", 64'(exp_beats.size()), 64'd0);
    check("save_in_ready", 64'(in_ready_seen), 64'd0);
  endtask

  task automatic run_restore(input int mode, input int stop_after);
    int   cnt = 0, n = 0;
    logic hs;
    wr_t  w;
    done_cnt = 0;
    restore_start = 1;
    @(posedge clk); #1;
    restore_start = 0;
    while (!done && n < 3000 && !(stop_after < NR && cnt >= stop_after)) begin
      if (cnt >= stop_after) in_valid = 0;
      else if (mode == 0)    in_valid = (n % 2) == 0;
      else                   in_valid = $urandom_range(0, 1) == 1;
      in_data = 64'hA5A5_0000 + 64'(cnt);
      @(negedge clk);
      hs = in_valid && in_ready;
      if (hs) begin
        w.addr = AW'(cnt);
        w.data = in_data;
        exp_wr.push_back(w);
        model_bank[cnt] = in_data;
        cnt++;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 0;
    if (stop_after == NR) begin
      check("restore_timeout", 64'(n >= 3000), 64'd0);
      @(posedge clk); #1;
      check("restore_busy_after", 64'(busy), 64'd0);
      check("restore_done_pulses", 64'(done_cnt), 64'd1);
      check("restore_accepts", 64'(cnt), 64'(NR));
      check("restore_writes_left", 64'(exp_wr.size()), 64'd0);
    end
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < NR; i++) check(tag, bank[i], model_bank[i]);
  endtask

  initial begin
    int n;
    for (int i = 0; i < NR; i++) model_bank[i] = 64'h1000 + 64'(i);
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_read_addr", 64'(rb_read_addr), 64'd0);
    check("reset_write_addr", 64'(rb_write_addr), 64'd0);
    @(negedge clk);
    rst_n = 1; preload = 0;
    @(posedge clk); #1;

    // Full-rate save: latency and back-to-back beats.
    run_save(0, 0);
    check("save_first_latency", 64'(first_beat_cyc - start_cyc), 64'd2);
    check("save_burst_span", 64'(last_beat_cyc - first_beat_cyc), 64'(NR - 1));

    run_save(1, 0);

    run_restore(0, NR);
    check_bank("bank_after_restore");

    run_save(2, 0);
    run_save(2, 1);

    // Reset in the middle of a save, then a clean save from index 0.
    beats = 0;
    push_save();
    save_start = 1; out_ready = 1;
    @(posedge clk); #1;
    save_start = 0;
    n = 0;
    while (beats < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_save_timeout", 64'(n >= 200), 64'd0);
    #2 rst_n = 0;
    #1 check_idle_outputs("save_abort");
    exp_beats.delete();
    stalled = 0; out_ready = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    run_save(0, 0);

    // Reset between restore accepts 5 and 6.
    run_restore(0, 5);
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1 check_idle_outputs("restore_abort");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    check("abort_writes_left", 64'(exp_wr.size()), 64'd0);
    check_bank("bank_after_abort");

    run_restore(1, NR);
    check_bank("bank_after_random_restore");
    run_save(2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
